// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised counter and its prescaler.
package param_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_STEP
   } op_e;

   // Never returns 0 so a register sized with it always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      bits = 0;
      while ((64'(1) << bits) < 64'(value)) bits++;
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

// File: rtl/param_counter_prescaler.sv
// Clock-enable divider: one step pulse every PRESCALE enabled, non-restarted edges.
module param_counter_prescaler
   import param_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic restart,
   output logic step
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         logic unused_bypass;
         assign unused_bypass = clk ^ reset_n;
         assign step          = en & ~restart;
      end else begin : g_div
         localparam int unsigned    PW   = clog2(PRESCALE);
         localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (restart) begin
               cnt_d = '0;
            end else if (en) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign step = en & ~restart & (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/param_counter.sv
// Up/down modulo counter with load, clear, optional saturation, tc pulse and sticky wrap flag.
module param_counter
   import param_counter_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = '1,
   parameter int unsigned      SATURATE = MODE_WRAP,
   parameter int unsigned      PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   input  logic             wrap_clr,
   output logic [WIDTH-1:0] result,
   output logic             tc,
   output logic             wrap_sticky
);

   logic [WIDTH-1:0] result_q, result_d;
   logic             tc_q, tc_d;
   logic             wrap_q, wrap_d;
   logic             step;
   logic             at_bound;
   op_e              op;

   param_counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .restart (clear | load),
      .step    (step)
   );

   always_comb begin
      op = OP_HOLD;
      if (clear) begin
         op = OP_CLEAR;
      end else if (load) begin
         op = OP_LOAD;
      end else if (step) begin
         op = OP_STEP;
      end
   end

   assign at_bound = (up_dn == DIR_UP) ? (result_q == MAX_VAL) : (result_q == '0);

   // Sticky set takes precedence over wrap_clr when both land on the same edge.
   always_comb begin
      result_d = result_q;
      tc_d     = 1'b0;
      wrap_d   = wrap_q & ~wrap_clr;
      unique case (op)
         OP_CLEAR: result_d = '0;
         OP_LOAD:  result_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         OP_STEP: begin
            if (at_bound) begin
               tc_d   = 1'b1;
               wrap_d = 1'b1;
               if (SATURATE == MODE_SAT) begin
                  result_d = result_q;
               end else begin
                  result_d = (up_dn == DIR_UP) ? '0 : MAX_VAL;
               end
            end else begin
               result_d = (up_dn == DIR_UP) ? result_q + 1'b1 : result_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result_q <= '0;
         tc_q     <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         tc_q     <= tc_d;
         wrap_q   <= wrap_d;
      end
   end

   assign result      = result_q;
   assign tc          = tc_q;
   assign wrap_sticky = wrap_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: four configurations share stimulus, checked against a behavioural model and fixed vectors.
`timescale 1ns/1ps
module tb_param_counter;
   import param_counter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, up_dn, load, clear, wrap_clr;
   logic [7:0] load_val;
   logic [3:0][7:0] res;
   logic [3:0]      tc_v, wr_v;

   param_counter u_def (
      .clk(clk), .reset_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .wrap_clr(wrap_clr), .result(res[0]), .tc(tc_v[0]), .wrap_sticky(wr_v[0]));
   param_counter #(.MAX_VAL(8'd9)) u_mod (
      .clk(clk), .reset_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .wrap_clr(wrap_clr), .result(res[1]), .tc(tc_v[1]), .wrap_sticky(wr_v[1]));
   param_counter #(.SATURATE(MODE_SAT)) u_sat (
      .clk(clk), .reset_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .wrap_clr(wrap_clr), .result(res[2]), .tc(tc_v[2]), .wrap_sticky(wr_v[2]));
   param_counter #(.PRESCALE(4)) u_pre (
      .clk(clk), .reset_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .wrap_clr(wrap_clr), .result(res[3]), .tc(tc_v[3]), .wrap_sticky(wr_v[3]));

   int unsigned cfg_max [4] = '{255, 9, 255, 255};
   int unsigned cfg_sat [4] = '{0, 0, 1, 0};
   int unsigned cfg_pre [4] = '{1, 1, 1, 4};

   int unsigned m_res [4];
   int unsigned m_pc  [4];
   bit          m_tc  [4];
   bit          m_wr  [4];

   typedef struct {
      logic [3:0][7:0] r;
      logic [3:0]      t;
      logic [3:0]      w;
   } exp_t;
   exp_t sb_q [$];

   typedef struct {
      logic e, u, ld;
      logic [7:0] lv;
      logic cl, wc;
      int unsigned sel;
      logic [7:0] r;
      logic t, w;
   } vec_t;
   vec_t vecs [18];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int k, input int unsigned r, input logic t, input logic w);
      check({nm, "_res"},  32'(res[k]),  r);
      check({nm, "_tc"},   32'(tc_v[k]), 32'(t));
      check({nm, "_wrap"}, 32'(wr_v[k]), 32'(w));
   endtask

   task automatic model_edge();
      for (int k = 0; k < 4; k++) begin
         bit          bev;
         bit          stp;
         int unsigned nres;
         bev  = 1'b0;
         stp  = 1'b0;
         nres = m_res[k];
         if (!rst_n) begin
            m_res[k] = 0; m_pc[k] = 0; m_tc[k] = 1'b0; m_wr[k] = 1'b0;
         end else begin
            if (clear) begin
               nres = 0; m_pc[k] = 0;
            end else if (load) begin
               nres = (int'(load_val) > cfg_max[k]) ? cfg_max[k] : int'(load_val);
               m_pc[k] = 0;
            end else if (en) begin
               if (m_pc[k] + 1 == cfg_pre[k]) begin
                  m_pc[k] = 0; stp = 1'b1;
               end else begin
                  m_pc[k] = m_pc[k] + 1;
               end
            end
            if (stp) begin
               if (up_dn) begin
                  if (m_res[k] == cfg_max[k]) begin
                     bev = 1'b1; nres = (cfg_sat[k] != 0) ? cfg_max[k] : 0;
                  end else nres = m_res[k] + 1;
               end else begin
                  if (m_res[k] == 0) begin
                     bev = 1'b1; nres = (cfg_sat[k] != 0) ? 0 : cfg_max[k];
                  end else nres = m_res[k] - 1;
               end
            end
            m_res[k] = nres;
            m_tc[k]  = bev;
            m_wr[k]  = bev | (m_wr[k] & ~wrap_clr);
         end
      end
   endtask

   task automatic cyc(input logic e, input logic u, input logic ld, input logic [7:0] lv,
                      input logic cl, input logic wc, input logic rn);
      exp_t x;
      en = e; up_dn = u; load = ld; load_val = lv; clear = cl; wrap_clr = wc; rst_n = rn;
      model_edge();
      for (int k = 0; k < 4; k++) begin
         x.r[k] = 8'(m_res[k]);
         x.t[k] = m_tc[k];
         x.w[k] = m_wr[k];
      end
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         x = sb_q.pop_front();
         for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_res%0d", k),  32'(res[k]),  32'(x.r[k]));
            check($sformatf("sb_tc%0d", k),   32'(tc_v[k]), 32'(x.t[k]));
            check($sformatf("sb_wrap%0d", k), 32'(wr_v[k]), 32'(x.w[k]));
         end
      end
   endtask

   task automatic run(input int n, input logic e, input logic u);
      for (int i = 0; i < n; i++) cyc(e, u, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
   endtask

   function automatic vec_t mk(input logic e, input logic u, input logic ld, input logic [7:0] lv,
                               input logic cl, input logic wc, input int unsigned sel,
                               input logic [7:0] r, input logic t, input logic w);
      vec_t v;
      v.e = e; v.u = u; v.ld = ld; v.lv = lv; v.cl = cl; v.wc = wc;
      v.sel = sel; v.r = r; v.t = t; v.w = w;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(1, 1, 1, 8'd3,   0, 0, 0, 8'd3,   0, 0);
      vecs[1]  = mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd2,   0, 0);
      vecs[2]  = mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd1,   0, 0);
      vecs[3]  = mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd0,   0, 0);
      vecs[4]  = mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd255, 1, 1);
      vecs[5]  = mk(0, 0, 0, 8'd0,   0, 1, 0, 8'd255, 0, 0);
      vecs[6]  = mk(1, 0, 1, 8'd12,  0, 0, 1, 8'd9,   0, 0);
      vecs[7]  = mk(1, 0, 1, 8'd0,   0, 0, 1, 8'd0,   0, 0);
      vecs[8]  = mk(1, 0, 0, 8'd0,   0, 0, 1, 8'd9,   1, 1);
      vecs[9]  = mk(1, 1, 1, 8'd254, 0, 1, 2, 8'd254, 0, 0);
      vecs[10] = mk(1, 1, 0, 8'd0,   0, 0, 2, 8'd255, 0, 0);
      vecs[11] = mk(1, 1, 0, 8'd0,   0, 0, 2, 8'd255, 1, 1);
      vecs[12] = mk(1, 1, 0, 8'd0,   0, 0, 2, 8'd255, 1, 1);
      vecs[13] = mk(1, 0, 0, 8'd0,   0, 0, 2, 8'd254, 0, 1);
      vecs[14] = mk(1, 1, 1, 8'd50,  1, 0, 0, 8'd0,   0, 1);
      vecs[15] = mk(1, 1, 1, 8'd255, 0, 1, 0, 8'd255, 0, 0);
      vecs[16] = mk(1, 1, 0, 8'd0,   0, 1, 0, 8'd0,   1, 1);
      vecs[17] = mk(1, 1, 0, 8'd0,   0, 0, 0, 8'd1,   0, 1);

      rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clear = 1'b0; wrap_clr = 1'b0;

      // Default configuration: free run, reset, full wrap
      cyc(1, 1, 0, 8'd0, 0, 0, 0);
      cyc(1, 1, 0, 8'd0, 0, 0, 0);
      for (int k = 0; k < 4; k++) chk_all($sformatf("reset%0d", k), k, 0, 1'b0, 1'b0);
      run(127, 1, 1);
      check("run127_res", 32'(res[0]), 32'd127);
      cyc(1, 1, 0, 8'd0, 0, 0, 0);
      check("rst_mid_res", 32'(res[0]), 32'd0);
      run(255, 1, 1);
      chk_all("run255", 0, 255, 1'b0, 1'b0);
      run(1, 1, 1);
      chk_all("wrap_edge", 0, 0, 1'b1, 1'b1);
      run(1, 1, 1);
      chk_all("post_wrap", 0, 1, 1'b0, 1'b1);

      // MAX_VAL=9 free run from reset
      cyc(1, 1, 0, 8'd0, 0, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         run(1, 1, 1);
         check($sformatf("mod_run%0d_res", i), 32'(res[1]), 32'(i % 10));
         check($sformatf("mod_run%0d_tc", i),  32'(tc_v[1]), (i % 10 == 0) ? 32'd1 : 32'd0);
      end

      for (int i = 0; i < 18; i++) begin
         cyc(vecs[i].e, vecs[i].u, vecs[i].ld, vecs[i].lv, vecs[i].cl, vecs[i].wc, 1'b1);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].sel), int'(vecs[i].r), vecs[i].t, vecs[i].w);
      end

      // Reset dominates a simultaneous load
      run(5, 1, 1);
      cyc(1, 1, 1, 8'd77, 0, 0, 0);
      for (int k = 0; k < 4; k++) chk_all($sformatf("rst_load%0d", k), k, 0, 1'b0, 1'b0);

      // PRESCALE=4: steps on every fourth enabled edge, en=0 freezes the phase
      for (int i = 1; i <= 12; i++) begin
         run(1, 1, 1);
         check($sformatf("pre_e%0d_res", i), 32'(res[3]), 32'(i / 4));
      end
      run(2, 1, 1);
      check("pre_mid_res", 32'(res[3]), 32'd3);
      run(5, 0, 1);
      check("pre_hold_res", 32'(res[3]), 32'd3);
      run(1, 1, 1);
      check("pre_resume1_res", 32'(res[3]), 32'd3);
      run(1, 1, 1);
      check("pre_resume2_res", 32'(res[3]), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
